graph_lut_stream_engine: RTL and testbench
==========================================

Name: graph_lut_stream_engine

Overview:
- Initiator-side streaming engine that drives a 1-cycle-latency, 256-entry int8 activation LUT (RSQRT, exp, GELU, etc.) from a scratchpad read port.
- Reads CMD length int8 elements from scratchpad starting at a source address and presents each byte as the LUT address.
- Collects the registered LUT result and emits it on a valid/ready output stream with a last flag.
- Sits between the graph scheduler and the graph LUT ROMs; one instance per LUT-type element-wise op.

Parameters:
- ADDR_W, 16, scratchpad byte-address width.
- LEN_W, 16, element-count width.
- FIFO_DEPTH, 4, output FIFO entries; power of 2, minimum 4.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_src_addr  in  ADDR_W  first element address.
- cmd_len  in  LEN_W  element count; 0 is legal.
- mem_rd_en  out  1  scratchpad read strobe.
- mem_rd_addr  out  ADDR_W  scratchpad read address.
- mem_rd_data  in  8  read data, valid exactly 1 cycle after mem_rd_en.
- lut_addr  out  8  LUT index, equal to mem_rd_data passed through combinationally.
- lut_data  in  8  LUT result, valid 1 cycle after lut_addr.
- out_valid  out  1  output element valid.
- out_ready  in  1  downstream accept.
- out_data  out  8  signed int8 LUT result.
- out_last  out  1  marks the final element of a command.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Interface: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values: state=IDLE, mem_rd_en=0, mem_rd_addr=0, out_valid=0, out_last=0, out_data=0, done=0, busy=0, FIFO empty, all counters 0. lut_addr follows mem_rd_data.
- Reset mid-command: all in-flight pipeline stages and FIFO contents are discarded. No done pulse is issued.
- Handshakes: a command is accepted on cmd_valid && cmd_ready. An output transfers on out_valid && out_ready. out_data and out_last must hold stable while out_valid=1 and out_ready=0.
- Pipeline:
  - Cycle t: mem_rd_en=1, mem_rd_addr=src+i.
  - Cycle t+1: mem_rd_data arrives and drives lut_addr (s1 valid).
  - Cycle t+2: lut_data is written into the FIFO with last=(i==len-1) (s2 valid).
  - Minimum latency from read issue to out_valid is 3 cycles. The FIFO is non-fall-through, with a registered head.
- Credit rule: a read issues only when fifo_count + s1_valid + s2_valid < FIFO_DEPTH. This guarantees the FIFO never overflows and no stage ever stalls. Sustained throughput is 1 element/cycle while out_ready=1.
- Address arithmetic: mem_rd_addr = cmd_src_addr + issued_count, modulo 2^ADDR_W. Wrap-around past the top address is legal.
- FSM:
  - IDLE: cmd_ready=1. On accept with len=0: done pulses next cycle, no output, stays in IDLE. On accept with len>0: latch src and len, issued=0, go to RUN.
  - RUN: issue reads per the credit rule. On the cycle the last read issues (issued==len-1), go to DRAIN.
  - DRAIN: no reads. Wait for the transfer with out_last=1, then done=1 for one cycle, return to IDLE.
  - A new command can be accepted in the cycle after done.
- Simultaneous FIFO push and pop: count is unchanged. A pop when the FIFO is full and a push in the same cycle cannot occur because of the credit rule.
- out_last is asserted only on the element at index len-1. len=1 gives a single element with out_last=1.

Decomposition:
- Shared package graph_pkg:
  - typedef lut_eng_state_e {IDLE, RUN, DRAIN}.
  - Constant LUT_LATENCY=1.
  - Constant MEM_LATENCY=1.
- One natural sub-module: graph_lut_out_fifo, a synchronous FIFO of width 9 ({last, data}) and depth FIFO_DEPTH, with count output, async active-high reset.

Test Plan:
- Bench memory holds bytes 0x00,0x20,0x40,0x80,0x04 at 0x100; bench LUT is the RSQRT table; src=0x100, len=5, out_ready=1 -> out_data 127,32,23,127,91; out_last on the 5th element only; first out_valid 3 cycles after first mem_rd_en; done 1 cycle after the last transfer.
- len=0 accepted -> no mem_rd_en, no out_valid, done pulses once, cmd_ready stays 1.
- len=20 with out_ready held low -> exactly 4 reads issued, then mem_rd_en=0, FIFO full, out_data stable. Release out_ready -> all 20 elements arrive in order with no loss or duplication.
- Random out_ready (50%) with len=64 -> output sequence matches the reference model; fifo_count+inflight never exceeds 4.
- src=0xFFFE, len=4 -> mem_rd_addr sequence FFFE, FFFF, 0000, 0001.
- Assert rst during RUN with elements in flight -> all outputs return to reset values immediately, no done pulse; a following command len=2 completes correctly.

Source files
------------

// File: rtl/graph_pkg.sv
`default_nettype none
// ============================================================================
// Module : graph_pkg
// Brief  : Shared types and latency constants for the graph LUT stream engine.
// Rev    : 1.0
// ============================================================================
package graph_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } lut_eng_state_e;

   localparam int LUT_LATENCY = 1;
   localparam int MEM_LATENCY = 1;
   localparam int LUT_W       = 8;
   localparam int FIFO_W      = LUT_W + 1;
endpackage
`default_nettype wire

// File: rtl/graph_lut_stream_engine_if.sv
`default_nettype none
// ============================================================================
// Module : graph_lut_stream_engine_if
// Brief  : Command, scratchpad, LUT and output-stream bundle of the engine.
// Rev    : 1.0
// ============================================================================
interface graph_lut_stream_engine_if
   import graph_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int LEN_W  = 16
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_src_addr;
   logic [LEN_W-1:0]  cmd_len;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_rd_addr;
   logic [LUT_W-1:0]  mem_rd_data;
   logic [LUT_W-1:0]  lut_addr;
   logic [LUT_W-1:0]  lut_data;
   logic              out_valid;
   logic              out_ready;
   logic [LUT_W-1:0]  out_data;
   logic              out_last;
   logic              busy;
   logic              done;

   modport master (
      input  cmd_valid, cmd_src_addr, cmd_len, mem_rd_data, lut_data, out_ready,
      output cmd_ready, mem_rd_en, mem_rd_addr, lut_addr, out_valid, out_data,
             out_last, busy, done
   );

   modport slave (
      output cmd_valid, cmd_src_addr, cmd_len, mem_rd_data, lut_data, out_ready,
      input  cmd_ready, mem_rd_en, mem_rd_addr, lut_addr, out_valid, out_data,
             out_last, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/graph_lut_out_fifo.sv
`default_nettype none
// ============================================================================
// Module : graph_lut_out_fifo
// Brief  : Synchronous FIFO with registered head and occupancy count.
// Rev    : 1.0
// ============================================================================
module graph_lut_out_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 9,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic [CNT_W-1:0] o_count,
   output logic             o_empty
);
   localparam int c_PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0]   r_count;
   logic               w_full;
   logic               w_do_push;
   logic               w_do_pop;

   assign w_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_do_push = i_push && !w_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_data    = r_mem[r_rd_ptr];
   assign o_count   = r_count;

   // Depth is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_mem[k] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: rtl/graph_lut_stream_engine.sv
`default_nettype none
// ============================================================================
// Module : graph_lut_stream_engine
// Brief  : Streams scratchpad bytes through a registered LUT into an output FIFO.
// Rev    : 1.0
// ============================================================================
module graph_lut_stream_engine
   import graph_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int LEN_W      = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   graph_lut_stream_engine_if.master  bus
);
   localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int c_SUM_W = c_CNT_W + 1;
   localparam int c_PIPE  = MEM_LATENCY + LUT_LATENCY;

   lut_eng_state_e    r_state;
   logic [ADDR_W-1:0] r_src;
   logic [LEN_W-1:0]  r_len;
   logic [LEN_W-1:0]  r_issued;
   logic [c_PIPE-1:0] r_pipe_vld;
   logic [c_PIPE-1:0] r_pipe_last;
   logic              r_busy;
   logic              r_done;

   logic [c_CNT_W-1:0] w_fifo_count;
   logic [FIFO_W-1:0]  w_fifo_rdata;
   logic               w_fifo_empty;
   logic [c_SUM_W-1:0] w_inflight;
   logic               w_issue;
   logic               w_last_issue;
   logic               w_pop;

   // Reserve a FIFO slot for every element still travelling through mem/LUT.
   always_comb begin
      w_inflight = c_SUM_W'(w_fifo_count);
      for (int k = 0; k < c_PIPE; k++) begin
         w_inflight = w_inflight + c_SUM_W'(r_pipe_vld[k]);
      end
   end

   assign w_issue      = (r_state == RUN) && (w_inflight < c_SUM_W'(FIFO_DEPTH));
   assign w_last_issue = (r_issued == r_len - LEN_W'(1));
   assign w_pop        = bus.out_valid && bus.out_ready;

   assign bus.cmd_ready   = !r_busy;
   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.mem_rd_en   = w_issue;
   assign bus.mem_rd_addr = r_src + ADDR_W'(r_issued);
   assign bus.lut_addr    = bus.mem_rd_data;
   assign bus.out_valid   = !w_fifo_empty;
   assign bus.out_data    = w_fifo_rdata[LUT_W-1:0];
   assign bus.out_last    = w_fifo_rdata[FIFO_W-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pipe_vld  <= '0;
         r_pipe_last <= '0;
      end else begin
         r_pipe_vld  <= {r_pipe_vld[c_PIPE-2:0], w_issue};
         r_pipe_last <= {r_pipe_last[c_PIPE-2:0], w_issue && w_last_issue};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_src    <= '0;
         r_len    <= '0;
         r_issued <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  if (bus.cmd_len == '0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_src    <= bus.cmd_src_addr;
                     r_len    <= bus.cmd_len;
                     r_issued <= '0;
                     r_busy   <= 1'b1;
                     r_state  <= RUN;
                  end
               end
            end
            RUN: begin
               if (w_issue) begin
                  r_issued <= r_issued + LEN_W'(1);
                  if (w_last_issue) begin
                     r_state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (w_pop && bus.out_last) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   graph_lut_out_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (FIFO_W),
      .CNT_W (c_CNT_W)
   ) u_out_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (r_pipe_vld[c_PIPE-1]),
      .i_data  ({r_pipe_last[c_PIPE-1], bus.lut_data}),
      .i_pop   (w_pop),
      .o_data  (w_fifo_rdata),
      .o_count (w_fifo_count),
      .o_empty (w_fifo_empty)
   );
endmodule
`default_nettype wire

// File: tb/tb_graph_lut_stream_engine.sv
`default_nettype none
// ============================================================================
// Module : tb_graph_lut_stream_engine
// Brief  : Scoreboard bench with memory/LUT models for graph_lut_stream_engine.
// Rev    : 1.0
// ============================================================================
module tb_graph_lut_stream_engine;
   localparam int ADDR_W = 16;
   localparam int LEN_W  = 16;
   localparam int DEPTH  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   graph_lut_stream_engine_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

   graph_lut_stream_engine #(
      .ADDR_W     (ADDR_W),
      .LEN_W      (LEN_W),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [7:0] mem     [0:65535];
   logic [7:0] lut_tab [0:255];
   logic [7:0] m_rd = 8'h00;
   logic [7:0] m_lut = 8'h00;

   assign bus.mem_rd_data = m_rd;
   assign bus.lut_data    = m_lut;

   // One-cycle scratchpad and one-cycle LUT models.
   always @(posedge clk) begin
      if (bus.mem_rd_en) m_rd <= mem[bus.mem_rd_addr];
      m_lut <= lut_tab[bus.lut_addr];
   end

   int n_cmp = 0;
   int n_err = 0;
   logic [8:0]  exp_q[$];
   logic [15:0] addr_q[$];
   int cyc = 0;
   int n_done = 0;
   int done_before, cmd_rd, cmd_xfer, first_rd, first_ov, last_xfer, done_cyc, max_out;
   int rdy_mode = 0;
   logic prev_hold = 1'b0;
   logic [8:0] prev_word = '0;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            prev_hold = 1'b0;
            continue;
         end
         if (prev_hold) begin
            check("hold_valid", longint'(bus.out_valid), 1);
            check("hold_word", longint'({bus.out_last, bus.out_data}), longint'(prev_word));
         end
         if (bus.mem_rd_en) begin
            cmd_rd++;
            if (first_rd < 0) first_rd = cyc;
            n_cmp++;
            if (addr_q.size() == 0) begin
               n_err++;
               $display("FAIL rd_unexpected: got addr %0h expected no read", bus.mem_rd_addr);
            end else begin
               logic [15:0] ea;
               ea = addr_q.pop_front();
               if (bus.mem_rd_addr != ea) begin
                  n_err++;
                  $display("FAIL rd_addr: got %0h expected %0h", bus.mem_rd_addr, ea);
               end
            end
         end
         if (bus.out_valid && first_ov < 0) first_ov = cyc;
         if (bus.out_valid && bus.out_ready) begin
            cmd_xfer++;
            last_xfer = cyc;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL out_unexpected: got %0h expected no output", {bus.out_last, bus.out_data});
            end else begin
               logic [8:0] ew;
               ew = exp_q.pop_front();
               if ({bus.out_last, bus.out_data} != ew) begin
                  n_err++;
                  $display("FAIL out_word: got last=%0d data=%0d expected last=%0d data=%0d",
                           bus.out_last, $signed(bus.out_data), ew[8], $signed(ew[7:0]));
               end
            end
         end
         if (cmd_rd - cmd_xfer > max_out) max_out = cmd_rd - cmd_xfer;
         if (bus.done) begin
            n_done++;
            done_cyc = cyc;
         end
         prev_hold = bus.out_valid && !bus.out_ready;
         prev_word = {bus.out_last, bus.out_data};
      end
   endtask

   task automatic ready_drv();
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 0)      bus.out_ready = 1'b1;
         else if (rdy_mode == 1) bus.out_ready = 1'b0;
         else                    bus.out_ready = 1'($urandom % 2);
      end
   endtask

   task automatic start_cmd(input logic [15:0] src, input logic [15:0] len);
      for (int i = 0; i < int'(len); i++) begin
         logic [15:0] a;
         a = src + 16'(i);
         exp_q.push_back({(i == int'(len) - 1), lut_tab[mem[a]]});
         addr_q.push_back(a);
      end
      cmd_rd = 0; cmd_xfer = 0; first_rd = -1; first_ov = -1;
      last_xfer = -1; done_cyc = -1; max_out = 0;
      done_before = n_done;
      @(posedge clk);
      #1;
      bus.cmd_valid    = 1'b1;
      bus.cmd_src_addr = src;
      bus.cmd_len      = len;
      check("cmd_ready_at_accept", longint'(bus.cmd_ready), 1);
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic finish_cmd(input int len);
      int t;
      t = 0;
      while (n_done == done_before && t < 3000) begin
         @(negedge clk);
         #1;
         t++;
      end
      if (t >= 3000) begin
         n_cmp++;
         n_err++;
         $display("FAIL done_timeout: got no done after %0d cycles expected done", t);
         return;
      end
      check("exp_drained", exp_q.size(), 0);
      check("addr_drained", addr_q.size(), 0);
      check("reads_issued", cmd_rd, len);
      check("elements_out", cmd_xfer, len);
      if (len > 0) begin
         check("first_latency", first_ov - first_rd, 3);
         check("done_after_last", done_cyc - last_xfer, 1);
         check("outstanding_le_depth", longint'(max_out <= DEPTH), 1);
      end else begin
         check("len0_no_valid", first_ov, -1);
      end
      repeat (2) @(negedge clk);
      #1;
      check("done_once", n_done - done_before, 1);
      check("idle_cmd_ready", longint'(bus.cmd_ready), 1);
      check("idle_busy", longint'(bus.busy), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_out_valid"}, longint'(bus.out_valid), 0);
      check({tag, "_out_last"}, longint'(bus.out_last), 0);
      check({tag, "_out_data"}, longint'(bus.out_data), 0);
      check({tag, "_mem_rd_en"}, longint'(bus.mem_rd_en), 0);
      check({tag, "_mem_rd_addr"}, longint'(bus.mem_rd_addr), 0);
      check({tag, "_busy"}, longint'(bus.busy), 0);
      check({tag, "_done"}, longint'(bus.done), 0);
      check({tag, "_cmd_ready"}, longint'(bus.cmd_ready), 1);
   endtask

   initial begin
      int nd;
      // RSQRT table: 181.02/sqrt(x) rounded, saturated; non-positive inputs give 127.
      for (int i = 0; i < 256; i++) begin
         byte s;
         real v;
         int r;
         s = byte'(i);
         if (s <= 0) begin
            r = 127;
         end else begin
            v = 181.019336 / $sqrt(real'(s));
            r = $rtoi(v + 0.5);
            if (r > 127) r = 127;
         end
         lut_tab[i] = 8'(r);
      end
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      mem[16'h0100] = 8'h00;
      mem[16'h0101] = 8'h20;
      mem[16'h0102] = 8'h40;
      mem[16'h0103] = 8'h80;
      mem[16'h0104] = 8'h04;

      bus.cmd_valid    = 1'b0;
      bus.cmd_src_addr = '0;
      bus.cmd_len      = '0;
      bus.out_ready    = 1'b1;
      rdy_mode         = 0;
      fork
         monitor();
         ready_drv();
      join_none

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("in_reset");
      rst = 1'b0;
      @(negedge clk);
      #1;
      check_reset_outputs("after_reset");

      // Known RSQRT vector
      start_cmd(16'h0100, 16'd5);
      finish_cmd(5);

      // Zero-length command
      start_cmd(16'h0200, 16'd0);
      finish_cmd(0);

      // Backpressure: credit limit stops reads at FIFO depth
      rdy_mode = 1;
      start_cmd(16'h2000, 16'd20);
      repeat (15) @(negedge clk);
      #1;
      check("hold_reads", cmd_rd, DEPTH);
      check("hold_rd_en_low", longint'(bus.mem_rd_en), 0);
      check("hold_out_valid", longint'(bus.out_valid), 1);
      rdy_mode = 0;
      finish_cmd(20);

      // Random backpressure
      rdy_mode = 2;
      start_cmd(16'($urandom), 16'd64);
      finish_cmd(64);

      // Address wrap-around
      rdy_mode = 0;
      start_cmd(16'hFFFE, 16'd4);
      finish_cmd(4);

      // Reset with elements in flight
      start_cmd(16'h3000, 16'd30);
      repeat (8) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("mid_reset");
      exp_q.delete();
      addr_q.delete();
      nd = n_done;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("no_done_on_reset", n_done - nd, 0);
      start_cmd(16'h3100, 16'd2);
      finish_cmd(2);

      // Mixed random commands
      for (int k = 0; k < 6; k++) begin
         rdy_mode = int'($urandom % 3);
         if (rdy_mode == 1) rdy_mode = 2;
         start_cmd(16'($urandom), 16'($urandom_range(1, 40)));
         finish_cmd(cmd_len_last());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   function automatic int cmd_len_last();
      return int'(bus.cmd_len);
   endfunction
endmodule
`default_nettype wire
